// File: rtl/ycbcr_convert_pipe.sv
// Streaming RGB-to-YCbCr converter: 3-stage pipeline (capture, multiply, sum/round/clamp)
// with per-pixel BT.601 / BT.709 / bypass selection and valid/ready backpressure.
module ycbcr_convert_pipe #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [3*PIX_W-1:0] s_data,
    input  logic [1:0]         s_mode,
    input  logic               s_sof,
    input  logic               s_eol,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [3*PIX_W-1:0] m_data,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_sat,
    output logic               busy
);

    localparam int CW = FRAC_W + 2;
    localparam int PW = PIX_W + FRAC_W + 3;
    localparam int AW = PIX_W + FRAC_W + 4;

    // Coefficient magnitude given in millionths, rounded to FRAC_W fractional bits.
    function automatic int scale(input longint ppm);
        return int'((ppm * (longint'(1) << FRAC_W) + 64'sd500000) / 64'sd1000000);
    endfunction

    localparam int ONE  = 1 << FRAC_W;
    localparam int HALF = 1 << (FRAC_W - 1);

    // G column absorbs rounding so rows sum exactly to ONE (Y) or zero (Cb, Cr).
    localparam int Y601_R  = scale(64'sd299000);
    localparam int Y601_B  = scale(64'sd114000);
    localparam int Y601_G  = ONE - Y601_R - Y601_B;
    localparam int CB601_R = -scale(64'sd168736);
    localparam int CB601_G = -HALF - CB601_R;
    localparam int CR601_B = -scale(64'sd81312);
    localparam int CR601_G = -HALF - CR601_B;

    localparam int Y709_R  = scale(64'sd212600);
    localparam int Y709_B  = scale(64'sd72200);
    localparam int Y709_G  = ONE - Y709_R - Y709_B;
    localparam int CB709_R = -scale(64'sd114572);
    localparam int CB709_G = -HALF - CB709_R;
    localparam int CR709_B = -scale(64'sd45847);
    localparam int CR709_G = -HALF - CR709_B;

    localparam int COEF_601 [9] = '{Y601_R, Y601_G, Y601_B,
                                    CB601_R, CB601_G, HALF,
                                    HALF, CR601_G, CR601_B};
    localparam int COEF_709 [9] = '{Y709_R, Y709_G, Y709_B,
                                    CB709_R, CB709_G, HALF,
                                    HALF, CR709_G, CR709_B};

    localparam logic signed [AW-1:0] RND     = AW'(1) << (FRAC_W - 1);
    localparam logic signed [AW-1:0] OFS     = AW'(1) << (PIX_W - 1 + FRAC_W);
    localparam logic signed [AW-1:0] PIX_MAX = (AW'(1) << PIX_W) - AW'(1);

    logic adv;

    // Stage 1
    logic             v1_q;
    logic [PIX_W-1:0] r1_q, g1_q, b1_q;
    logic [1:0]       mode1_q;
    logic             sof1_q, eol1_q;

    // Stage 2
    logic                     v2_q;
    logic signed [PW-1:0]     prod_q [9];
    logic signed [PW-1:0]     prod_d [9];
    logic [3*PIX_W-1:0]       pix2_q;
    logic                     byp2_q, sof2_q, eol2_q;

    // Stage 3 (output registers)
    logic               v3_q;
    logic [3*PIX_W-1:0] data3_q;
    logic               sof3_q, eol3_q, sat3_q;

    logic signed [PIX_W:0]  ch1 [3];
    logic signed [CW-1:0]   coef_sel;
    logic signed [AW-1:0]   acc [3];
    logic signed [AW-1:0]   res [3];
    logic [3*PIX_W-1:0]     data_d;
    logic                   sat_d;

    assign adv     = !v3_q || m_ready;
    assign s_ready = adv;
    assign m_valid = v3_q;
    assign m_data  = data3_q;
    assign m_sof   = sof3_q;
    assign m_eol   = eol3_q;
    assign m_sat   = sat3_q;
    assign busy    = v1_q || v2_q || v3_q;

    always_comb begin
        ch1[0]   = {1'b0, r1_q};
        ch1[1]   = {1'b0, g1_q};
        ch1[2]   = {1'b0, b1_q};
        coef_sel = '0;
        for (int i = 0; i < 9; i++) begin
            coef_sel  = (mode1_q == 2'd1) ? CW'(COEF_709[i]) : CW'(COEF_601[i]);
            prod_d[i] = PW'(coef_sel) * PW'(ch1[i % 3]);
        end
    end

    always_comb begin
        data_d = '0;
        sat_d  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            acc[k] = AW'(prod_q[3*k]) + AW'(prod_q[3*k+1]) + AW'(prod_q[3*k+2]) + RND;
            if (k != 0) begin
                acc[k] = acc[k] + OFS;
            end
            res[k] = acc[k] >>> FRAC_W;
            if (res[k][AW-1]) begin
                data_d[k*PIX_W +: PIX_W] = '0;
                sat_d = 1'b1;
            end else if (res[k] > PIX_MAX) begin
                data_d[k*PIX_W +: PIX_W] = '1;
                sat_d = 1'b1;
            end else begin
                data_d[k*PIX_W +: PIX_W] = res[k][PIX_W-1:0];
            end
        end
        if (byp2_q) begin
            data_d = pix2_q;
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            r1_q    <= '0;
            g1_q    <= '0;
            b1_q    <= '0;
            mode1_q <= '0;
            sof1_q  <= 1'b0;
            eol1_q  <= 1'b0;
            v2_q    <= 1'b0;
            prod_q  <= '{default: '0};
            pix2_q  <= '0;
            byp2_q  <= 1'b0;
            sof2_q  <= 1'b0;
            eol2_q  <= 1'b0;
            v3_q    <= 1'b0;
            data3_q <= '0;
            sof3_q  <= 1'b0;
            eol3_q  <= 1'b0;
            sat3_q  <= 1'b0;
        end else if (adv) begin
            v1_q <= s_valid;
            if (s_valid) begin
                r1_q    <= s_data[PIX_W-1:0];
                g1_q    <= s_data[2*PIX_W-1:PIX_W];
                b1_q    <= s_data[3*PIX_W-1:2*PIX_W];
                mode1_q <= s_mode;
                sof1_q  <= s_sof;
                eol1_q  <= s_eol;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                prod_q <= prod_d;
                pix2_q <= {b1_q, g1_q, r1_q};
                byp2_q <= mode1_q[1];
                sof2_q <= sof1_q;
                eol2_q <= eol1_q;
            end
            v3_q <= v2_q;
            if (v2_q) begin
                data3_q <= data_d;
                sof3_q  <= sof2_q;
                eol3_q  <= eol2_q;
                sat3_q  <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_convert_pipe.sv
// Randomised self-checking bench for ycbcr_convert_pipe against an integer reference model.
module tb_ycbcr_convert_pipe;

    localparam int PIX_W  = 8;
    localparam int FRAC_W = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_sof, s_eol;
    logic [23:0] s_data;
    logic [1:0]  s_mode;
    logic        m_valid, m_ready, m_sof, m_eol, m_sat, busy;
    logic [23:0] m_data;

    int errors = 0;
    int checks = 0;

    localparam int C601 [9] = '{2449, 4809, 934, -1382, -2714, 4096, 4096, -3430, -666};
    localparam int C709 [9] = '{1742, 5859, 591, -939, -3157, 4096, 4096, -3720, -376};

    ycbcr_convert_pipe #(.PIX_W(PIX_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode),
        .s_sof(s_sof), .s_eol(s_eol),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_sat(m_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Returns {sat, Cr, Cb, Y} (or {0, B, G, R} for bypass).
    function automatic logic [24:0] model(input int r, input int g, input int b, input int mode);
        logic [23:0] d;
        logic        sat;
        int          acc, v;
        if (mode >= 2) return {1'b0, 8'(b), 8'(g), 8'(r)};
        d   = '0;
        sat = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (mode == 0) acc = C601[3*k]*r + C601[3*k+1]*g + C601[3*k+2]*b;
            else           acc = C709[3*k]*r + C709[3*k+1]*g + C709[3*k+2]*b;
            acc = acc + 4096 + ((k == 0) ? 0 : 128 * 8192);
            v   = acc >>> 13;
            if (v < 0) begin
                v = 0; sat = 1'b1;
            end else if (v > 255) begin
                v = 255; sat = 1'b1;
            end
            d[8*k +: 8] = 8'(v);
        end
        return {sat, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int r, input int g, input int b, input int mode,
                         input logic sof, input logic eol);
        s_valid = v;
        s_data  = {8'(b), 8'(g), 8'(r)};
        s_mode  = 2'(mode);
        s_sof   = sof;
        s_eol   = eol;
    endtask

    // Injects one pixel with m_ready high and reports cycles until m_valid (-1 on timeout).
    task automatic send_one(input int r, input int g, input int b, input int mode, output int lat);
        m_ready = 1'b1;
        drive(1'b1, r, g, b, mode, 1'b0, 1'b0);
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            s_valid = 1'b0;
            if (m_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b1;
        drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        tick(); tick();
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if ({m_sof, m_eol, m_sat, m_data} !== 27'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {m_sof, m_eol, m_sat, m_data});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        tick();
    endtask

    task automatic test_bt601();
        int lat;
        int px [4][3] = '{'{255, 255, 255}, '{0, 0, 0}, '{255, 0, 0}, '{0, 0, 255}};
        logic [24:0] want [4] = '{{1'b0, 24'h8080FF}, {1'b0, 24'h808000},
                                  {1'b1, 24'hFF554C}, {1'b1, 24'h6BFF1D}};
        for (int i = 0; i < 4; i++) begin
            send_one(px[i][0], px[i][1], px[i][2], 0, lat);
            checks++;
            if (lat != 3) begin errors++; $display("FAIL bt601_latency[%0d]: got %0d expected 3", i, lat); end
            checks++;
            if ({m_sat, m_data} !== want[i]) begin
                errors++; $display("FAIL bt601_pixel[%0d]: got %h expected %h", i, {m_sat, m_data}, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int lat, r, g, b, mode;
        logic [24:0] exp_v;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 255); g = $urandom_range(0, 255);
            b = $urandom_range(0, 255); mode = $urandom_range(0, 3);
            exp_v = model(r, g, b, mode);
            send_one(r, g, b, mode, lat);
            checks++;
            if (lat != 3 || {m_sat, m_data} !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got lat=%0d %h expected lat=3 %h", i, lat, {m_sat, m_data}, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_mode_switch();
        int          modes [4] = '{0, 1, 2, 0};
        int          want_y [4] = '{76, 54, 255, 76};
        logic [23:0] got_d [8];
        int          got_c [8];
        int          n = 0;
        logic [24:0] exp_v;
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (m_valid && n < 8) begin
                got_d[n] = m_data; got_c[n] = c; n++;
            end
            if (c < 4) drive(1'b1, 255, 0, 0, modes[c], 1'b0, 1'b0);
            else       s_valid = 1'b0;
            tick();
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL mode_count: got %0d expected 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            exp_v = model(255, 0, 0, modes[i]);
            checks++;
            if (got_c[i] != i + 3 || got_d[i] !== exp_v[23:0] || int'(got_d[i][7:0]) != want_y[i]) begin
                errors++;
                $display("FAIL mode_pixel[%0d]: got cyc=%0d %h expected cyc=%0d %h", i, got_c[i],
                         got_d[i], i + 3, exp_v[23:0]);
            end
        end
        checks++;
        if (n >= 3 && got_d[2] !== 24'h0000FF) begin
            errors++; $display("FAIL mode_bypass: got %h expected 0000ff", got_d[2]);
        end
    endtask

    task automatic test_bubbles();
        int   pat [5] = '{1, 0, 1, 1, 0};
        logic exp_v;
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            exp_v = (c >= 3 && c < 8) ? 1'(pat[c-3]) : 1'b0;
            checks++;
            if (m_valid !== exp_v) begin
                errors++; $display("FAIL bubble_cyc%0d: got %b expected %b", c, m_valid, exp_v);
            end
            if (c < 5) drive(1'(pat[c]), $urandom_range(0, 255), 7, 9, 0, 1'b0, 1'b0);
            else       s_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back_backpressure();
        int          pr [20], pg [20], pb [20], pm [20];
        logic [26:0] exp_q [20];
        int          sent = 0, rcv = 0;
        logic        stall = 1'b0;
        logic [26:0] held = '0;
        for (int i = 0; i < 20; i++) begin
            pr[i] = $urandom_range(0, 255); pg[i] = $urandom_range(0, 255);
            pb[i] = $urandom_range(0, 255); pm[i] = $urandom_range(0, 3);
            exp_q[i] = {1'(i == 0), 1'(i == 19), model(pr[i], pg[i], pb[i], pm[i])};
        end
        for (int cyc = 0; cyc < 600 && rcv < 20; cyc++) begin
            if (stall) begin
                checks++;
                if (!m_valid || {m_sof, m_eol, m_sat, m_data} !== held) begin
                    errors++;
                    $display("FAIL bp_stable: got v=%b %h expected v=1 %h", m_valid,
                             {m_sof, m_eol, m_sat, m_data}, held);
                end
            end
            m_ready = ($urandom_range(0, 99) < 55);
            if (sent < 20) drive(1'b1, pr[sent], pg[sent], pb[sent], pm[sent], sent == 0, sent == 19);
            else           s_valid = 1'b0;
            #1;
            checks++;
            if (s_ready !== !(m_valid && !m_ready)) begin
                errors++; $display("FAIL bp_s_ready: got %b expected %b", s_ready, !(m_valid && !m_ready));
            end
            if (m_valid && m_ready) begin
                checks++;
                if ({m_sof, m_eol, m_sat, m_data} !== exp_q[rcv]) begin
                    errors++;
                    $display("FAIL bp_pixel[%0d]: got %h expected %h", rcv,
                             {m_sof, m_eol, m_sat, m_data}, exp_q[rcv]);
                end
                rcv++;
            end
            stall = m_valid && !m_ready;
            held  = {m_sof, m_eol, m_sat, m_data};
            if (s_valid && s_ready) sent++;
            tick();
        end
        checks++;
        if (rcv != 20) begin errors++; $display("FAIL bp_count: got %0d expected 20", rcv); end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick(); tick(); tick(); tick();
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_drain: got v=%b busy=%b expected 0 0", m_valid, busy);
        end
    endtask

    task automatic test_reset_midstream();
        int lat, r, g, b;
        logic [24:0] exp_v;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10 * i, 20, 30, 0, 1'b0, 1'b0);
            tick();
        end
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_preload: got v=%b busy=%b expected 1 1", m_valid, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got v=%b busy=%b expected 0 0", m_valid, busy);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
        exp_v = model(r, g, b, 1);
        send_one(r, g, b, 1, lat);
        checks++;
        if (lat != 3 || {m_sat, m_data} !== exp_v) begin
            errors++;
            $display("FAIL mid_first_pixel: got lat=%0d %h expected lat=3 %h", lat, {m_sat, m_data}, exp_v);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_bt601();
        test_random();
        test_mode_switch();
        test_bubbles();
        test_back_to_back_backpressure();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
